// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo datapath constants: bus widths, CDB source indices, null tag.
package tomasulo_pkg;

   localparam int unsigned DATA_W      = 32;
   localparam int unsigned LABEL_W     = 4;
   localparam int unsigned NUM_CDB_SRC = 4;

   // Result producers feeding the common data bus, by request-vector position.
   typedef enum logic [1:0] {
      SRC_ALU = 2'd0,
      SRC_MUL = 2'd1,
      SRC_DIV = 2'd2,
      SRC_LS  = 2'd3
   } cdb_src_e;

   // Reservation-station tag 0 means "no label".
   localparam int unsigned LABEL_NONE = 0;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-to-CDB handshake and broadcast bus bundle.
interface cdb_arbiter_if #(
   parameter int unsigned NUM_SRC = tomasulo_pkg::NUM_CDB_SRC,
   parameter int unsigned DATA_W  = tomasulo_pkg::DATA_W,
   parameter int unsigned LABEL_W = tomasulo_pkg::LABEL_W
);
   logic [NUM_SRC-1:0]         require;
   logic [NUM_SRC*DATA_W-1:0]  data_in;
   logic [NUM_SRC*LABEL_W-1:0] label_in;
   logic                       flush;
   logic [NUM_SRC-1:0]         requireAC;
   logic                       BCEN;
   logic [DATA_W-1:0]          BCdata;
   logic [LABEL_W-1:0]         BClabel;
   logic                       err_label0;

   // Producer / environment side.
   modport master (
      output require, data_in, label_in, flush,
      input  requireAC, BCEN, BCdata, BClabel, err_label0
   );

   // Arbiter side.
   modport slave (
      input  require, data_in, label_in, flush,
      output requireAC, BCEN, BCdata, BClabel, err_label0
   );
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin one-hot picker: first set req bit at or after ptr, circularly.
module rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] grant_idx
);

   // Circular scan from ptr; the first requester found wins.
   always_comb begin
      int unsigned idx;
      logic        found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned off = 0; off < N; off++) begin
         idx = int'(ptr) + off;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx[PTR_W-1:0]]) begin
            found                  = 1'b1;
            grant[idx[PTR_W-1:0]]  = 1'b1;
            grant_idx              = idx[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Registered, round-robin, flushable common-data-bus arbiter.
module cdb_arbiter #(
   parameter int unsigned NUM_SRC = tomasulo_pkg::NUM_CDB_SRC,
   parameter int unsigned DATA_W  = tomasulo_pkg::DATA_W,
   parameter int unsigned LABEL_W = tomasulo_pkg::LABEL_W
) (
   input  logic         clk,
   input  logic         nRST,
   cdb_arbiter_if.slave bus
);
   import tomasulo_pkg::*;

   localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [PTR_W-1:0]   rr_ptr;
   logic [NUM_SRC-1:0] req_eff;
   logic [NUM_SRC-1:0] grant;
   logic [PTR_W-1:0]   grant_idx;
   logic               any_grant;
   logic [DATA_W-1:0]  win_data;
   logic [LABEL_W-1:0] win_label;
   logic               bc_en;
   logic [DATA_W-1:0]  bc_data;
   logic [LABEL_W-1:0] bc_label;
   logic               err_l0;

   // Reset (active-high here) and flush both mask every request.
   assign req_eff = (nRST || bus.flush) ? '0 : bus.require;

   rr_pick #(.N(NUM_SRC), .PTR_W(PTR_W)) u_pick (
      .req       (req_eff),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign any_grant = |grant;

   // One-hot AND-OR mux selecting the winner's data and label.
   always_comb begin
      win_data  = '0;
      win_label = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (grant[i]) begin
            win_data  = win_data  | bus.data_in[i*DATA_W +: DATA_W];
            win_label = win_label | bus.label_in[i*LABEL_W +: LABEL_W];
         end
      end
   end

   // Broadcast register, round-robin pointer advance and sticky null-tag error.
   always_ff @(posedge clk) begin
      if (nRST) begin
         rr_ptr   <= '0;
         bc_en    <= 1'b0;
         bc_data  <= '0;
         bc_label <= '0;
         err_l0   <= 1'b0;
      end else if (any_grant) begin
         bc_en    <= 1'b1;
         bc_data  <= win_data;
         bc_label <= win_label;
         rr_ptr   <= (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + PTR_W'(1);
         if (win_label == LABEL_W'(LABEL_NONE)) err_l0 <= 1'b1;
      end else begin
         bc_en    <= 1'b0;
         bc_data  <= '0;
         bc_label <= '0;
      end
   end

   assign bus.requireAC  = grant;
   assign bus.BCEN       = bc_en;
   assign bus.BCdata     = bc_data;
   assign bus.BClabel    = bc_label;
   assign bus.err_label0 = err_l0;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected broadcasts are queued when a cycle is driven
// and compared after the following rising edge.
module tb_cdb_arbiter;

   localparam int unsigned NS = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned LW = 4;

   typedef struct packed {
      logic          en;
      logic [DW-1:0] data;
      logic [LW-1:0] label;
      logic          err;
   } bc_t;

   logic clk;
   logic nRST;

   cdb_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW), .LABEL_W(LW)) ifc ();

   cdb_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .LABEL_W(LW)) dut (
      .clk  (clk),
      .nRST (nRST),
      .bus  (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [DW-1:0] src_data [NS];
   logic [LW-1:0] src_lbl  [NS];
   logic [NS-1:0] req;
   logic          flsh;

   int unsigned   m_ptr;
   logic          m_err;
   bc_t           sb_q [$];
   logic [NS-1:0] last_ac;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NS-1:0] model_grant();
      logic [NS-1:0] g;
      int unsigned   idx;
      g = '0;
      if (nRST || flsh) return g;
      for (int unsigned off = 0; off < NS; off++) begin
         idx = (m_ptr + off) % NS;
         if (req[idx]) begin
            g[idx] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   task automatic drive();
      ifc.require = req;
      ifc.flush   = flsh;
      for (int unsigned i = 0; i < NS; i++) begin
         ifc.data_in[i*DW +: DW]  = src_data[i];
         ifc.label_in[i*LW +: LW] = src_lbl[i];
      end
   endtask

   // One clock: check grant mid-cycle, queue the expected broadcast, then compare after the edge.
   task automatic cycle(input string tag);
      logic [NS-1:0] g;
      bc_t           e;
      bc_t           got;
      int unsigned   gi;
      drive();
      @(negedge clk);
      g = model_grant();
      check({tag, "_ac"}, 64'(ifc.requireAC), 64'(g));
      last_ac = ifc.requireAC;
      gi = 0;
      for (int unsigned i = 0; i < NS; i++) if (g[i]) gi = i;
      if (nRST) begin
         e = '0;
         m_ptr = 0;
         m_err = 1'b0;
      end else if (g != '0) begin
         e.en    = 1'b1;
         e.data  = src_data[gi];
         e.label = src_lbl[gi];
         if (src_lbl[gi] == '0) m_err = 1'b1;
         m_ptr = (gi + 1) % NS;
      end else begin
         e.en    = 1'b0;
         e.data  = '0;
         e.label = '0;
      end
      e.err = m_err;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      // accepted producers present a fresh result next cycle
      if (g != '0) begin
         src_data[gi] = $urandom;
         src_lbl[gi]  = LW'($urandom_range(1, 15));
      end
      got.en    = ifc.BCEN;
      got.data  = ifc.BCdata;
      got.label = ifc.BClabel;
      got.err   = ifc.err_label0;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_bcen"},  64'(got.en),    64'(e.en));
         check({tag, "_data"},  64'(got.data),  64'(e.data));
         check({tag, "_label"}, 64'(got.label), 64'(e.label));
         check({tag, "_err"},   64'(got.err),   64'(e.err));
      end
   endtask

   initial begin
      m_ptr = 0;
      m_err = 1'b0;
      flsh  = 1'b0;
      for (int unsigned i = 0; i < NS; i++) begin
         src_data[i] = 32'h1000_0000 + i;
         src_lbl[i]  = LW'(i + 1);
      end

      // reset held with all sources requesting
      nRST = 1'b1;
      req  = 4'b1111;
      cycle("rst0");
      cycle("rst1");
      check("rst_bcen_c", 64'(ifc.BCEN), 64'd0);

      // single request from source 1
      nRST = 1'b0;
      req  = 4'b0010;
      src_lbl[1]  = 4'd5;
      src_data[1] = 32'hDEADBEEF;
      cycle("single");
      check("single_ac_c",    64'(last_ac),     64'h2);
      check("single_label_c", 64'(ifc.BClabel), 64'h5);
      check("single_data_c",  64'(ifc.BCdata),  64'hDEADBEEF);
      req = 4'b0000;
      cycle("idle");
      // rr_ptr is now 2: source 2 must beat source 0
      req = 4'b0101;
      cycle("ptr2");
      check("ptr2_ac_c", 64'(last_ac), 64'h4);

      // back to ptr 0 via reset, then saturate
      nRST = 1'b1;
      cycle("rst2");
      nRST = 1'b0;
      req  = 4'b1111;
      for (int unsigned k = 0; k < 8; k++) begin
         cycle($sformatf("sat%0d", k));
         check($sformatf("sat%0d_order", k), 64'(last_ac), 64'(1) << (k % 4));
         check($sformatf("sat%0d_bcen_c", k), 64'(ifc.BCEN), 64'd1);
      end

      // set ptr to 1, then wrap from 3 back to 0
      req = 4'b0001;
      cycle("toptr1");
      req = 4'b1001;
      src_lbl[3] = 4'd9;
      src_lbl[0] = 4'd6;
      cycle("wrap0");
      check("wrap0_ac_c",  64'(last_ac),     64'h8);
      check("wrap0_lbl_c", 64'(ifc.BClabel), 64'h9);
      cycle("wrap1");
      check("wrap1_ac_c",  64'(last_ac),     64'h1);
      check("wrap1_lbl_c", 64'(ifc.BClabel), 64'h6);

      // set ptr to 2, then flush two cycles with source 2 waiting
      req = 4'b0010;
      cycle("toptr2");
      req  = 4'b0100;
      flsh = 1'b1;
      cycle("flush0");
      cycle("flush1");
      check("flush_bcen_c", 64'(ifc.BCEN), 64'd0);
      flsh = 1'b0;
      cycle("postflush");
      check("postflush_ac_c",   64'(last_ac),  64'h4);
      check("postflush_bcen_c", 64'(ifc.BCEN), 64'd1);

      // null label: broadcast still happens, error latches, reset clears while BCEN=1
      req = 4'b0001;
      src_lbl[0]  = 4'd0;
      src_data[0] = 32'hCAFE_0000;
      cycle("lbl0");
      check("lbl0_err_c",  64'(ifc.err_label0), 64'd1);
      check("lbl0_bcen_c", 64'(ifc.BCEN),       64'd1);
      req = 4'b0010;
      cycle("lbl0_next");
      check("lbl0_sticky_c", 64'(ifc.err_label0), 64'd1);
      nRST = 1'b1;
      cycle("rst_final");
      check("rst_final_bcen_c", 64'(ifc.BCEN),       64'd0);
      check("rst_final_err_c",  64'(ifc.err_label0), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Responder end of the function-unit → common-data-bus require/accept handshake. It collects `require` from up to NUM_SRC result producers (ALU, MUL, DIV, load/store), grants one per cycle by round-robin, and registers the winner's data and label onto the broadcast bus. Reservation stations and the register file consume that bus (BCEN/BClabel/BCdata). It replaces the purely combinational arbitration-plus-mux with a registered, fair, flushable stage.

Parameters:
- NUM_SRC, 4, number of requesting producers; index 0=ALU, 1=MUL, 2=DIV, 3=LS.
- DATA_W, 32, result data width.
- LABEL_W, 4, reservation-station tag width; tag 0 means "no label".

Ports:
- clk  in  1  single clock, rising edge.
- nRST  in  1  reset. Synchronous and active-high in this block, despite the name: 1 on a rising edge resets.
- require  in  NUM_SRC  per-source request; held with data/label until accepted.
- data_in  in  NUM_SRC*DATA_W  flattened result data; source i occupies bits [i*DATA_W +: DATA_W].
- label_in  in  NUM_SRC*LABEL_W  flattened result tags; same packing.
- flush  in  1  suppresses all grants this cycle and cancels the broadcast due next cycle.
- requireAC  out  NUM_SRC  one-hot grant, combinational from require/rr_ptr/flush.
- BCEN  out  1  broadcast valid, registered.
- BCdata  out  DATA_W  broadcast data, registered.
- BClabel  out  LABEL_W  broadcast tag, registered.
- err_label0  out  1  sticky: a granted request carried tag 0.

Behaviour:
- Internal state:
  - rr_ptr, width clog2(NUM_SRC), reset 0.
  - Output registers BCEN, BCdata, BClabel, err_label0, all reset 0.
- Grant (combinational):
  - Scan sources circularly starting at rr_ptr; the first i with require[i]=1 gets requireAC[i]=1.
  - All other bits are 0. At most one bit is ever set.
  - If flush=1 or require=0, requireAC=0.
- Handshake:
  - A source is accepted on the rising edge where require[i]&requireAC[i]=1.
  - The source may drop require, or present its next result, in the following cycle.
  - An unaccepted source must hold require, data and label stable.
- Broadcast, on a rising edge with nRST=0:
  - If a grant exists: BCEN<=1, BCdata<=data_in[g], BClabel<=label_in[g], rr_ptr<=(g==NUM_SRC-1)?0:g+1.
  - Otherwise: BCEN<=0, BCdata<=0, BClabel<=0, rr_ptr unchanged.
  - Latency is exactly 1 cycle from acceptance to BCEN=1. Throughput is one broadcast per cycle.
- Fairness: under continuous requests from k sources, each is granted once every k cycles. No starvation.
- Flush: with flush=1 at an edge, BCEN<=0, data/label<=0 and rr_ptr is held. Requesters keep require high and are granted after flush drops, in round-robin order from the held rr_ptr.
- err_label0: set on any edge where the granted label is 0. The broadcast still occurs. Cleared only by reset.
- Reset: nRST=1 at an edge clears all registers, regardless of pending requests or broadcast. requireAC is forced to 0 while nRST=1.
- Wrap-around: rr_ptr wraps from NUM_SRC-1 to 0. For non-power-of-two NUM_SRC, values ≥NUM_SRC never occur.
- Simultaneous events: if a source is accepted in the same cycle it is being broadcast from an earlier grant, that is a legal back-to-back broadcast.

Decomposition:
- Shared package tomasulo_pkg holds:
  - DATA_W, LABEL_W, NUM_CDB_SRC.
  - Source indices SRC_ALU=0, SRC_MUL=1, SRC_DIV=2, SRC_LS=3.
  - LABEL_NONE=0.
- One sub-module: rr_pick. It is a combinational round-robin one-hot picker with inputs req and ptr, and outputs grant and grant_idx. It is reusable by issue logic.

Test Plan:
- Reset check: hold nRST=1 for 2 cycles with require=4'b1111 → requireAC=0, and after the edge BCEN=0, BCdata=0, BClabel=0, err_label0=0.
- Single request: require=4'b0010, label 5, data 32'hDEADBEEF, from reset → requireAC=4'b0010 in the same cycle. Next cycle BCEN=1, BClabel=5, BCdata=32'hDEADBEEF, and rr_ptr=2.
- Saturation: require=4'b1111 held 8 cycles, rr_ptr=0 → grant order 0,1,2,3,0,1,2,3 and BCEN=1 on every cycle after the first.
- Wrap-around: rr_ptr=1, require=4'b1001 held → grant 3 first, then 0. Broadcast labels match the sources in that order.
- Flush: flush=1 for 2 cycles while require=4'b0100 and rr_ptr=2 → requireAC=0 and BCEN=0 during flush. In the first cycle after flush, source 2 is granted and broadcast 1 cycle later.
- Label 0 and reset: grant source 0 with label 0 → broadcast occurs and err_label0 rises and stays 1. Then assert nRST in the cycle BCEN=1 → BCEN and err_label0 are 0 after that edge.
